axil_user_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single user-side command port of axilite_master between NUM_REQ independent requesters.
- Each requester gets one outstanding AXI-Lite read or write at a time.
- A watchdog returns an error response when a transaction never completes.
- Sits between register-access clients (config sequencer, debug port, interrupt service logic) and axilite_master, which in turn drives the vertexinput register file.

---
 rtl/axil_user_arbiter.sv | 154 +++++++++++++++
 tb/tb_axil_user_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_user_arbiter.sv
// Round-robin arbiter sharing the axilite_master user command port between
// NUM_REQ requesters, one transaction in flight system-wide, with a watchdog.
module axil_user_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_w_r,
    input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]      req_data,
    input  logic [NUM_REQ*(DATA_W/8)-1:0]  req_strb,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [DATA_W-1:0]              rsp_data,
    output logic [1:0]                     rsp_status,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           user_start,
    output logic                           user_w_r,
    output logic [ADDR_W-1:0]              user_addr_in,
    output logic [DATA_W-1:0]              user_data_in,
    output logic [DATA_W/8-1:0]            user_data_strb,
    input  logic                           user_free,
    input  logic [1:0]                     user_status,
    input  logic [DATA_W-1:0]              user_data_out,
    input  logic                           user_data_out_valid
);

    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              timed_out;

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic [STRB_W-1:0] strb_arr [NUM_REQ];

    logic [ID_W-1:0]   sel;
    logic [ID_W-1:0]   idx;
    logic              any_sel;
    logic              grant_fire;

    // Unflatten the per-requester payload buses
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        assign strb_arr[gi] = req_strb[gi*STRB_W +: STRB_W];
    end

    // First valid requester searching upward from last_grant+1 with wrap
    always_comb begin
        sel     = '0;
        idx     = '0;
        any_sel = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((32'(last_grant) + k) % NUM_REQ);
            if (!any_sel && req_valid[idx]) begin
                sel     = idx;
                any_sel = 1'b1;
            end
        end
    end

    assign grant_fire = (state == S_IDLE) && user_free && any_sel && !areset;
    assign req_ready  = grant_fire ? (NUM_REQ'(1'b1) << sel) : '0;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state          <= S_IDLE;
            last_grant     <= ID_W'(NUM_REQ - 1);
            tmo_cnt        <= '0;
            timed_out      <= 1'b0;
            grant_id       <= '0;
            rsp_valid      <= '0;
            rsp_data       <= '0;
            rsp_status     <= '0;
            user_start     <= 1'b0;
            user_w_r       <= 1'b0;
            user_addr_in   <= '0;
            user_data_in   <= '0;
            user_data_strb <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_fire) begin
                        user_w_r       <= req_w_r[sel];
                        user_addr_in   <= addr_arr[sel];
                        user_data_in   <= data_arr[sel];
                        user_data_strb <= strb_arr[sel];
                        grant_id       <= sel;
                        last_grant     <= sel;
                        user_start     <= 1'b1;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    user_start <= 1'b0;
                    tmo_cnt    <= '0;
                    state      <= S_WAIT;
                end
                // A completion on the expiry cycle still counts as a normal completion
                S_WAIT: begin
                    if (user_data_out_valid) begin
                        rsp_data   <= user_w_r ? '0 : user_data_out;
                        rsp_status <= user_status;
                        timed_out  <= 1'b0;
                        rsp_valid  <= NUM_REQ'(1'b1) << grant_id;
                        state      <= S_RESP;
                    end else if ((TIMEOUT_CYC != 0) && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1))) begin
                        rsp_data   <= '0;
                        rsp_status <= 2'b11;
                        timed_out  <= 1'b1;
                        rsp_valid  <= NUM_REQ'(1'b1) << grant_id;
                        state      <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready[grant_id]) begin
                        rsp_valid <= '0;
                        state     <= timed_out ? S_DRAIN : S_IDLE;
                    end
                end
                // Wait for the master to shake off the abandoned transaction
                S_DRAIN: begin
                    if (user_free) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_user_arbiter.sv
// Randomized bench for axil_user_arbiter: behavioural master, requesters and a
// timestamp-based transaction model predicting every output each cycle.
module tb_axil_user_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 16;
    localparam int unsigned IW = $clog2(NR);
    localparam int NEVER = 1 << 30;

    logic              aclk = 1'b0;
    logic              areset;
    logic [NR-1:0]     req_valid, req_ready, req_w_r, rsp_valid, rsp_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR*SW-1:0]  req_strb;
    logic [DW-1:0]     rsp_data;
    logic [1:0]        rsp_status;
    logic [IW-1:0]     grant_id;
    logic              busy, user_start, user_w_r;
    logic [AW-1:0]     user_addr_in;
    logic [DW-1:0]     user_data_in;
    logic [SW-1:0]     user_data_strb;
    logic              user_free;
    logic [1:0]        user_status;
    logic [DW-1:0]     user_data_out;
    logic              user_data_out_valid;

    axil_user_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_w_r(req_w_r),
        .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .grant_id(grant_id), .busy(busy),
        .user_start(user_start), .user_w_r(user_w_r), .user_addr_in(user_addr_in),
        .user_data_in(user_data_in), .user_data_strb(user_data_strb),
        .user_free(user_free), .user_status(user_status),
        .user_data_out(user_data_out), .user_data_out_valid(user_data_out_valid)
    );

    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // requesters and stimulus knobs
    logic [NR-1:0] pend;
    logic          rq_w [NR];
    logic [AW-1:0] rq_a [NR];
    logic [DW-1:0] rq_d [NR];
    logic [SW-1:0] rq_s [NR];
    logic [NR-1:0] en_mask;
    int p_new, p_drop, p_rdy, p_unfree, fixed_lat;
    bit stall, release_now;

    // behavioural master
    bit            m_busy;
    int            m_due;
    logic [DW-1:0] mem [32];

    // transaction-level expectation
    int g_cyc, r_cyc, idle_from, last_grant, owner;
    bit rsp_pend, tmo, done, drain_wait, chk_zero;
    logic          exp_w;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d, exp_rd;
    logic [SW-1:0] exp_s;
    logic [1:0]    exp_st;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v);
        for (int k = 1; k <= int'(NR); k++) begin
            int i = (last_grant + k) % int'(NR);
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        last_grant = NR - 1;
        owner      = 0;
        g_cyc      = -NEVER;
        r_cyc      = NEVER;
        idle_from  = 0;
        rsp_pend   = 0;
        drain_wait = 0;
        done       = 1;
        tmo        = 0;
        exp_w = 1'b0; exp_a = '0; exp_d = '0; exp_s = '0;
        m_busy = 0;
        m_due  = NEVER;
        pend   = '0;
    endtask

    task automatic new_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        pend[i] = 1'b1;
        rq_w[i] = w; rq_a[i] = a; rq_d[i] = d; rq_s[i] = s;
    endtask

    task automatic cycle(input bit rst);
        logic [NR-1:0] exp_rv, exp_rr;
        bit allowed;
        int pick;
        @(posedge aclk);
        cyc++;
        #1;
        // registered outputs against the model
        check_eq("user_start", user_start, cyc == g_cyc + 1);
        check_eq("busy", busy, cyc < idle_from);
        check_eq("grant_id", grant_id, owner);
        check_eq("user_addr", user_addr_in, exp_a);
        check_eq("user_data", user_data_in, exp_d);
        check_eq("user_wr_strb", {user_w_r, user_data_strb}, {exp_w, exp_s});
        exp_rv = (rsp_pend && cyc >= r_cyc) ? (NR'(1) << owner) : '0;
        check_eq("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv != '0) begin
            check_eq("rsp_data", rsp_data, exp_rd);
            check_eq("rsp_status", rsp_status, exp_st);
        end
        if (chk_zero) begin
            check_eq("rst_rsp_data", rsp_data, 0);
            check_eq("rst_rsp_status", rsp_status, 0);
            chk_zero = 0;
        end

        // master side drive
        areset = rst;
        if (!rst && cyc == g_cyc + 1) begin
            m_busy = 1;
            m_due  = stall ? NEVER : (fixed_lat > 0 ? cyc + fixed_lat : cyc + int'($urandom_range(1, 4)));
        end
        if (release_now && m_busy) m_due = cyc;
        release_now = 0;
        user_data_out_valid = 1'b0;
        user_data_out       = $urandom;
        user_status         = 2'($urandom_range(0, 3));
        if (m_busy && cyc == m_due) begin
            user_data_out_valid = 1'b1;
            m_busy = 0;
            if (!done && !rst && cyc >= g_cyc + 2 && cyc <= g_cyc + 1 + int'(TO)) begin
                if (exp_w) begin
                    for (int b = 0; b < int'(SW); b++)
                        if (exp_s[b]) mem[exp_a[6:2]][b*8 +: 8] = exp_d[b*8 +: 8];
                    exp_rd = '0;
                end else begin
                    exp_rd        = mem[exp_a[6:2]];
                    user_data_out = exp_rd;
                end
                exp_st      = (exp_a >= AW'(32'h40)) ? 2'b10 : 2'b00;
                user_status = exp_st;
                done = 1; rsp_pend = 1; tmo = 0; r_cyc = cyc + 1;
            end
        end
        if (!done && !rst && cyc == g_cyc + 1 + int'(TO)) begin
            exp_rd = '0; exp_st = 2'b11;
            done = 1; rsp_pend = 1; tmo = 1; r_cyc = cyc + 1;
        end
        user_free = !m_busy && ($urandom_range(0, 99) >= p_unfree);

        // requester side drive
        for (int i = 0; i < int'(NR); i++) begin
            if (!pend[i] && en_mask[i] && $urandom_range(0, 99) < p_new)
                new_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31) * 4), $urandom,
                        SW'($urandom_range(1, (1 << SW) - 1)));
            else if (pend[i] && $urandom_range(0, 99) < p_drop)
                pend[i] = 1'b0;
            req_w_r[i] = rq_w[i];
            req_addr[i*AW +: AW] = rq_a[i];
            req_data[i*DW +: DW] = rq_d[i];
            req_strb[i*SW +: SW] = rq_s[i];
            rsp_ready[i] = ($urandom_range(0, 99) < p_rdy);
        end
        req_valid = pend;
        #1;

        if (drain_wait && user_free && !rst) begin
            drain_wait = 0;
            idle_from  = cyc + 1;
        end
        allowed = !rst && cyc >= idle_from && user_free && (pend != '0);
        pick    = allowed ? rr_pick(pend) : 0;
        exp_rr  = allowed ? (NR'(1) << pick) : '0;
        check_eq("req_ready", req_ready, exp_rr);
        if (allowed) begin
            owner = pick; last_grant = pick; g_cyc = cyc;
            idle_from = NEVER; done = 0;
            exp_w = rq_w[pick]; exp_a = rq_a[pick]; exp_d = rq_d[pick]; exp_s = rq_s[pick];
            pend[pick] = 1'b0;
        end
        if (!rst && rsp_pend && cyc >= r_cyc && rsp_ready[owner]) begin
            rsp_pend = 0;
            if (tmo) drain_wait = 1;
            else     idle_from = cyc + 1;
        end
        if (rst) begin
            model_reset();
            chk_zero = 1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    initial begin
        areset = 1'b1;
        req_valid = '0; req_w_r = '0; req_addr = '0; req_data = '0; req_strb = '0;
        rsp_ready = '0; user_free = 1'b1; user_status = '0; user_data_out = '0;
        user_data_out_valid = 1'b0;
        for (int i = 0; i < int'(NR); i++) begin
            rq_w[i] = 1'b0; rq_a[i] = '0; rq_d[i] = '0; rq_s[i] = '0;
        end
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[1] = 32'h01AB_CDEF;
        en_mask = '1; p_new = 0; p_drop = 0; p_rdy = 100; p_unfree = 0;
        fixed_lat = 0; stall = 0; release_now = 0; chk_zero = 0;
        model_reset();
        repeat (2) @(posedge aclk);
        cycle(1'b1);

        // single read, single write, config readback
        new_req(0, 1'b0, 32'h04, '0, '0);          run(10);
        new_req(1, 1'b1, 32'h00, 32'h3, 4'hF);     run(10);
        new_req(1, 1'b0, 32'h00, '0, '0);          run(10);

        // two requesters contending continuously
        en_mask = 3'b011; p_new = 100;             run(60);
        p_new = 0;                                 run(12);

        // response backpressure with a competitor waiting
        new_req(0, 1'b0, 32'h10, '0, '0);
        new_req(1, 1'b1, 32'h14, 32'hCAFE_F00D, 4'h5);
        p_rdy = 0;                                 run(20);
        p_rdy = 100;                               run(20);

        // watchdog expiry, drain, late completion ignored
        stall = 1;
        new_req(2, 1'b0, 32'h08, '0, '0);          run(5);
        new_req(0, 1'b0, 32'h0C, '0, '0);          run(25);
        release_now = 1; stall = 0;                run(15);

        // completion exactly on expiry, then one cycle too late
        fixed_lat = TO;
        new_req(1, 1'b0, 32'h04, '0, '0);          run(25);
        fixed_lat = TO + 1;
        new_req(2, 1'b1, 32'h18, 32'h1234_5678, 4'hF); run(25);
        fixed_lat = 0;

        // reset in the middle of a transaction
        stall = 1;
        new_req(0, 1'b0, 32'h20, '0, '0);          run(5);
        cycle(1'b1);
        stall = 0;
        new_req(0, 1'b0, 32'h24, '0, '0);
        new_req(1, 1'b0, 32'h28, '0, '0);          run(15);

        // randomized traffic
        en_mask = '1; p_new = 40; p_drop = 10; p_rdy = 60; p_unfree = 20;
        run(3000);
        p_new = 0; p_drop = 0; p_rdy = 100; p_unfree = 0;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
